// File: rtl/sdram_init_refresh.sv
// SDRAM power-up sequencer and periodic AUTO REFRESH arbiter. It sits between the
// controller's command outputs and the SDRAM pins and owns the bus during init/refresh.
module sdram_init_refresh #(
    parameter int          INIT_WAIT_CYC  = 20000,
    parameter int          TRP            = 2,
    parameter int          TRFC           = 7,
    parameter int          TMRD           = 2,
    parameter int          INIT_REFRESHES = 2,
    parameter int          REF_INTERVAL   = 780,
    parameter logic [12:0] MODE_REG       = 13'h020
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [3:0]  ctl_cmd,
    input  logic [1:0]  ctl_ba,
    input  logic [12:0] ctl_addr,
    input  logic        ctl_idle,
    output logic        ctl_hold,
    output logic        init_done,
    output logic        ref_miss,
    output logic [3:0]  sdr_cmd,
    output logic [1:0]  sdr_ba,
    output logic [12:0] sdr_addr,
    output logic        sdr_cke
);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    localparam int MAX_AB  = (TRP > TRFC) ? TRP : TRFC;
    localparam int MAX_ABC = (MAX_AB > TMRD) ? MAX_AB : TMRD;
    localparam int CNT_MAX = (MAX_ABC > INIT_WAIT_CYC) ? MAX_ABC : INIT_WAIT_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int NREF_W  = (INIT_REFRESHES > 1) ? $clog2(INIT_REFRESHES) : 1;
    localparam int TMR_W   = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

    // Wait states last T-1 cycles, so they end when the counter reaches T-2.
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(INIT_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0]  TRP_LAST  = CNT_W'(TRP - 2);
    localparam logic [CNT_W-1:0]  TRFC_LAST = CNT_W'(TRFC - 2);
    localparam logic [CNT_W-1:0]  TMRD_LAST = CNT_W'(TMRD - 2);
    localparam logic [NREF_W-1:0] NREF_LAST = NREF_W'(INIT_REFRESHES - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(REF_INTERVAL - 1);

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_INIT_PRE,
        ST_INIT_PRE_W,
        ST_INIT_REF,
        ST_INIT_REF_W,
        ST_INIT_MRS,
        ST_INIT_MRS_W,
        ST_PASS,
        ST_REF_CMD,
        ST_REF_W
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NREF_W-1:0]  nref_q, nref_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               pending_q, pending_d;
    logic               miss_q, miss_d;
    logic               done_q, done_d;
    logic               cke_q, cke_d;
    logic               ref_take;
    logic               tmr_wrap;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= ST_INIT_WAIT;
            cnt_q     <= '0;
            nref_q    <= '0;
            tmr_q     <= '0;
            pending_q <= 1'b0;
            miss_q    <= 1'b0;
            done_q    <= 1'b0;
            cke_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nref_q    <= nref_d;
            tmr_q     <= tmr_d;
            pending_q <= pending_d;
            miss_q    <= miss_d;
            done_q    <= done_d;
            cke_q     <= cke_d;
        end
    end

    // Next-state logic. The power-up wait only counts once CKE is high, so the
    // reset-release edge itself is not part of the wait interval.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        nref_d   = nref_q;
        done_d   = done_q;
        cke_d    = 1'b1;
        ref_take = 1'b0;
        case (state_q)
            ST_INIT_WAIT: begin
                if (cke_q) begin
                    if (cnt_q == WAIT_LAST) begin
                        state_d = ST_INIT_PRE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_INIT_PRE: begin
                state_d = ST_INIT_PRE_W;
                cnt_d   = '0;
            end
            ST_INIT_PRE_W: begin
                if (cnt_q == TRP_LAST) begin
                    state_d = ST_INIT_REF;
                    nref_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_INIT_REF: begin
                state_d = ST_INIT_REF_W;
                cnt_d   = '0;
            end
            ST_INIT_REF_W: begin
                if (cnt_q == TRFC_LAST) begin
                    if (nref_q == NREF_LAST) begin
                        state_d = ST_INIT_MRS;
                    end else begin
                        state_d = ST_INIT_REF;
                        nref_d  = nref_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_INIT_MRS: begin
                state_d = ST_INIT_MRS_W;
                cnt_d   = '0;
            end
            ST_INIT_MRS_W: begin
                if (cnt_q == TMRD_LAST) begin
                    state_d = ST_PASS;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PASS: begin
                // Only steal the bus when the controller is idle and silent this cycle.
                if (pending_q && ctl_idle && (ctl_cmd == CMD_NOP)) begin
                    state_d  = ST_REF_CMD;
                    ref_take = 1'b1;
                end
            end
            ST_REF_CMD: begin
                state_d = ST_REF_W;
                cnt_d   = '0;
            end
            ST_REF_W: begin
                if (cnt_q == TRFC_LAST) begin
                    state_d = ST_PASS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Refresh interval timer; a request consumed on the same edge as a wrap is not a miss.
    always_comb begin
        tmr_d     = tmr_q;
        tmr_wrap  = 1'b0;
        if (done_q) begin
            if (tmr_q == TMR_LAST) begin
                tmr_d    = '0;
                tmr_wrap = 1'b1;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end
        pending_d = pending_q;
        if (ref_take) begin
            pending_d = 1'b0;
        end
        if (tmr_wrap) begin
            pending_d = 1'b1;
        end
        miss_d = miss_q | (tmr_wrap & pending_q & ~ref_take);
    end

    always_comb begin
        sdr_cmd  = CMD_NOP;
        sdr_ba   = 2'd0;
        sdr_addr = 13'd0;
        case (state_q)
            ST_PASS: begin
                sdr_cmd  = ctl_cmd;
                sdr_ba   = ctl_ba;
                sdr_addr = ctl_addr;
            end
            ST_INIT_PRE: begin
                sdr_cmd  = CMD_PRE;
                sdr_addr = 13'h400;
            end
            ST_INIT_REF, ST_REF_CMD: begin
                sdr_cmd = CMD_AREF;
            end
            ST_INIT_MRS: begin
                sdr_cmd  = CMD_LMR;
                sdr_addr = MODE_REG;
            end
            default: begin
                sdr_cmd = CMD_NOP;
            end
        endcase
    end

    assign ctl_hold  = ~done_q | pending_q | (state_q != ST_PASS);
    assign init_done = done_q;
    assign ref_miss  = miss_q;
    assign sdr_cke   = cke_q;

endmodule
